// File: rtl/expander_core.sv
// -----------------------------------------------------------------------------
// expander_core
//
// Combinational symbol decoder for the EBPC bit-plane expander. The next
// variable-length symbol sits MSB-aligned in data_i; this block classifies
// its prefix and produces the decoded DBX (or DBP) word, the zero-run
// extension and the symbol length class. It holds no state.
//
// Symbol prefixes, checked in priority order from data_i[DATA_W-1] down:
//   1        + 7 bits : uncompressed DBX
//   01                : single zero DBX
//   001      + r      : run of r+1 zero DBXs
//   00000             : all-ones DBX
//   00001             : DBP equal to zero
//   00010    + p      : two consecutive ones at bits p and p+1
//   00011    + p      : single one at bit p
//
// Ports:
//   clk_i      in   1              system clock (no state is clocked)
//   rst_ni     in   1              async active-low reset (no state to reset)
//   data_i     in   DATA_W         bit-stream window, symbol at MSB
//   zeros_o    out  LOG_DATA_W     extra zero DBXs beyond the current one
//   len_o      out  symb_len_t     symbol length class
//   dbx_dbp_o  out  BLOCK_SIZE-1   decoded DBX, or DBP when is_dbp_o=1
//   is_dbp_o   out  1              dbx_dbp_o carries a DBP
// -----------------------------------------------------------------------------

package ebpc_pkg;
  parameter int unsigned DATA_W     = 8;
  parameter int unsigned LOG_DATA_W = $clog2(DATA_W);
  parameter int unsigned BLOCK_SIZE = 8;
  parameter int unsigned LOGN       = $clog2(BLOCK_SIZE - 1);

  // Lengths: 2, 3+LOG_DATA_W, 5, 5+LOGN and BLOCK_SIZE bits respectively.
  typedef enum logic [2:0] {
    TWO,
    THREE_PLUS_LOGM,
    FIVE,
    FIVE_PLUS_LOGN,
    UNCOMPRESSED
  } symb_len_t;
endpackage

module expander_core
  import ebpc_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_W-1:0]       data_i,
  output logic [LOG_DATA_W-1:0]   zeros_o,
  output symb_len_t               len_o,
  output logic [BLOCK_SIZE-2:0]   dbx_dbp_o,
  output logic                    is_dbp_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time sanity checks: every symbol must fit in the window.
  // ---------------------------------------------------------------------------
  if (DATA_W < BLOCK_SIZE) begin : g_chk_block
    $error("expander_core: DATA_W must be >= BLOCK_SIZE");
  end
  if (DATA_W < 5 + LOGN) begin : g_chk_logn
    $error("expander_core: DATA_W must be >= 5+LOGN");
  end
  if (DATA_W < 3 + LOG_DATA_W) begin : g_chk_logm
    $error("expander_core: DATA_W must be >= 3+LOG_DATA_W");
  end

  // Clock and reset are part of the interface for pipeline integration only;
  // the decode is purely combinational and ignores them.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [LOG_DATA_W-1:0] run_len;   // r field after "001"
  logic [LOGN-1:0]       pos;       // p field after "0001x"

  assign run_len = data_i[DATA_W-4 -: LOG_DATA_W];
  assign pos     = data_i[DATA_W-6 -: LOGN];

  // One-hot for bit p in a vector wide enough for every p value plus one
  // guard bit; the guard absorbs p+1 in the two-ones case, and anything at or
  // above BLOCK_SIZE-1 is simply cut off when slicing to the output width.
  logic [(1<<LOGN):0] one_hot;
  logic [(1<<LOGN):0] two_hot;

  always_comb begin
    one_hot = {{(1<<LOGN){1'b0}}, 1'b1} << pos;
    two_hot = one_hot | (one_hot << 1);
  end

  // ---------------------------------------------------------------------------
  // Prefix decode
  // ---------------------------------------------------------------------------
  always_comb begin
    zeros_o   = '0;
    len_o     = FIVE;
    dbx_dbp_o = '0;
    is_dbp_o  = 1'b0;

    if (data_i[DATA_W-1]) begin
      len_o     = UNCOMPRESSED;
      dbx_dbp_o = data_i[DATA_W-2 -: BLOCK_SIZE-1];
    end else if (data_i[DATA_W-2]) begin
      len_o = TWO;
    end else if (data_i[DATA_W-3]) begin
      len_o   = THREE_PLUS_LOGM;
      zeros_o = run_len;
    end else if (!data_i[DATA_W-4]) begin
      len_o = FIVE;
      if (data_i[DATA_W-5]) begin
        is_dbp_o = 1'b1;             // "00001": DBP of zero
      end else begin
        dbx_dbp_o = '1;              // "00000": all-ones DBX
      end
    end else begin
      len_o = FIVE_PLUS_LOGN;
      if (data_i[DATA_W-5]) begin
        dbx_dbp_o = one_hot[BLOCK_SIZE-2:0];   // "00011": single one
      end else begin
        dbx_dbp_o = two_hot[BLOCK_SIZE-2:0];   // "00010": two ones
      end
    end
  end

endmodule

// File: tb/tb_expander_core.sv
// -----------------------------------------------------------------------------
// tb_expander_core
//
// Directed checks of the expander decode for DATA_W=8, BLOCK_SIZE=8, LOGN=3,
// followed by a sweep of every data_i value against an independent casez
// model while the clock runs and reset is pulsed part way through.
// -----------------------------------------------------------------------------
module tb_expander_core;
  import ebpc_pkg::*;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] data_i;
  logic [2:0] zeros_o;
  symb_len_t  len_o;
  logic [6:0] dbx_dbp_o;
  logic       is_dbp_o;

  int tests_run;
  int tests_failed;

  expander_core dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .zeros_o   (zeros_o),
    .len_o     (len_o),
    .dbx_dbp_o (dbx_dbp_o),
    .is_dbp_o  (is_dbp_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model, written straight from the symbol table.
  typedef struct packed {
    logic [2:0] len;
    logic [6:0] dbx;
    logic [2:0] zeros;
    logic       is_dbp;
  } exp_t;

  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    int   p;
    e = '{len: FIVE, dbx: 7'd0, zeros: 3'd0, is_dbp: 1'b0};
    p = int'(d[2:0]);
    casez (d)
      8'b1???????: begin e.len = UNCOMPRESSED; e.dbx = d[6:0]; end
      8'b01??????: e.len = TWO;
      8'b001?????: begin e.len = THREE_PLUS_LOGM; e.zeros = d[4:2]; end
      8'b00000???: begin e.len = FIVE; e.dbx = 7'h7F; end
      8'b00001???: begin e.len = FIVE; e.is_dbp = 1'b1; end
      8'b00010???: begin
        e.len = FIVE_PLUS_LOGN;
        for (int i = 0; i < 7; i++) if (i == p || i == p + 1) e.dbx[i] = 1'b1;
      end
      default: begin
        e.len = FIVE_PLUS_LOGN;
        for (int i = 0; i < 7; i++) if (i == p) e.dbx[i] = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Driver: apply a vector away from the rising edge, let it settle.
  task automatic drive(input logic [7:0] d);
    @(negedge clk_i);
    data_i = d;
    #2;
  endtask

  // Scoreboard check of all four outputs against one expected set.
  task automatic check(input string tag, input logic [2:0] e_len,
                       input logic [6:0] e_dbx, input logic [2:0] e_zeros,
                       input logic e_dbp);
    tests_run++;
    assert (3'(len_o) === e_len) else begin
      tests_failed++;
      $error("FAIL %s len data=%b got=%0d exp=%0d", tag, data_i, len_o, e_len);
    end
    tests_run++;
    assert (dbx_dbp_o === e_dbx) else begin
      tests_failed++;
      $error("FAIL %s dbx data=%b got=%b exp=%b", tag, data_i, dbx_dbp_o, e_dbx);
    end
    tests_run++;
    assert (zeros_o === e_zeros) else begin
      tests_failed++;
      $error("FAIL %s zeros data=%b got=%0d exp=%0d", tag, data_i, zeros_o, e_zeros);
    end
    tests_run++;
    assert (is_dbp_o === e_dbp) else begin
      tests_failed++;
      $error("FAIL %s is_dbp data=%b got=%b exp=%b", tag, data_i, is_dbp_o, e_dbp);
    end
  endtask

  initial begin
    exp_t e;
    tests_run    = 0;
    tests_failed = 0;
    rst_ni       = 1'b0;
    data_i       = 8'h00;

    // Reset held: outputs still follow data_i=0.
    drive(8'b0000_0000);
    check("reset_zero", FIVE, 7'h7F, 3'd0, 1'b0);
    drive(8'b1_0110011);
    check("reset_uncomp", UNCOMPRESSED, 7'b0110011, 3'd0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vectors.
    drive(8'b01_101101);  check("two",        TWO,             7'd0,       3'd0, 1'b0);
    drive(8'b001_101_11); check("run5",       THREE_PLUS_LOGM, 7'd0,       3'd5, 1'b0);
    drive(8'b001_000_11); check("run0",       THREE_PLUS_LOGM, 7'd0,       3'd0, 1'b0);
    drive(8'b001_111_00); check("run7",       THREE_PLUS_LOGM, 7'd0,       3'd7, 1'b0);
    drive(8'b00000_111);  check("all_ones",   FIVE,            7'h7F,      3'd0, 1'b0);
    drive(8'b00001_000);  check("dbp_zero",   FIVE,            7'd0,       3'd0, 1'b1);
    drive(8'b00001_101);  check("dbp_payld",  FIVE,            7'd0,       3'd0, 1'b1);
    drive(8'b00010_011);  check("two1_p3",    FIVE_PLUS_LOGN,  7'b0011000, 3'd0, 1'b0);
    drive(8'b00010_000);  check("two1_p0",    FIVE_PLUS_LOGN,  7'b0000011, 3'd0, 1'b0);
    drive(8'b00010_110);  check("two1_p6",    FIVE_PLUS_LOGN,  7'b1000000, 3'd0, 1'b0);
    drive(8'b00010_111);  check("two1_p7",    FIVE_PLUS_LOGN,  7'b0000000, 3'd0, 1'b0);
    drive(8'b00011_110);  check("one1_p6",    FIVE_PLUS_LOGN,  7'b1000000, 3'd0, 1'b0);
    drive(8'b00011_111);  check("one1_p7",    FIVE_PLUS_LOGN,  7'b0000000, 3'd0, 1'b0);
    drive(8'b00011_010);  check("one1_p2",    FIVE_PLUS_LOGN,  7'b0000100, 3'd0, 1'b0);
    drive(8'b1_1010101);  check("uncomp",     UNCOMPRESSED,    7'b1010101, 3'd0, 1'b0);
    drive(8'b1_0000000);  check("uncomp_zero", UNCOMPRESSED,   7'b0000000, 3'd0, 1'b0);

    // Exhaustive sweep with a reset pulse in the middle.
    for (int v = 0; v < 256; v++) begin
      if (v == 120) rst_ni = 1'b0;
      if (v == 136) rst_ni = 1'b1;
      drive(8'(v));
      e = model(8'(v));
      check("sweep", e.len, e.dbx, e.zeros, e.is_dbp);
      tests_run++;
      assert (!$isunknown({zeros_o, len_o, dbx_dbp_o, is_dbp_o})) else begin
        tests_failed++;
        $error("FAIL sweep_x data=%b got=%b exp=no X", data_i,
               {zeros_o, len_o, dbx_dbp_o, is_dbp_o});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
